// File: rtl/zilla_irq_responder_if.sv
// ZIC-facing and core-facing signal bundle for zilla_irq_responder.
// slave = responder side, master = ZIC/core side.
interface zilla_irq_responder_if #(
    parameter int ID_W = 8,
    parameter int LP_W = 8
);
    logic            interrupt_request_i;
    logic [LP_W-1:0] highest_pending_lvl_pr_i;
    logic [ID_W-1:0] zic_ack_int_id_i;
    logic            zic_ack_read_valid_en_o;
    logic            zic_eoi_valid_o;
    logic [ID_W-1:0] zic_eoi_id_o;
    logic [LP_W-1:0] active_lvl_pr_o;
    logic            irq_global_en_i;
    logic            debug_mode_valid_i;
    logic            trap_req_o;
    logic [ID_W-1:0] trap_id_o;
    logic            trap_ack_i;
    logic            irq_ret_i;
    logic [3:0]      nest_depth_o;
    logic            ret_err_o;

    modport slave (
        input  interrupt_request_i, highest_pending_lvl_pr_i, zic_ack_int_id_i,
        input  irq_global_en_i, debug_mode_valid_i, trap_ack_i, irq_ret_i,
        output zic_ack_read_valid_en_o, zic_eoi_valid_o, zic_eoi_id_o, active_lvl_pr_o,
        output trap_req_o, trap_id_o, nest_depth_o, ret_err_o
    );

    modport master (
        output interrupt_request_i, highest_pending_lvl_pr_i, zic_ack_int_id_i,
        output irq_global_en_i, debug_mode_valid_i, trap_ack_i, irq_ret_i,
        input  zic_ack_read_valid_en_o, zic_eoi_valid_o, zic_eoi_id_o, active_lvl_pr_o,
        input  trap_req_o, trap_id_o, nest_depth_o, ret_err_o
    );
endinterface

// File: rtl/zilla_irq_responder.sv
// Core-side ZIC interrupt responder: claim, trap hand-off, active stack and EOI.
// Define ZILLA_IRQ_NEST_EN to allow nesting up to NEST_DEPTH; otherwise depth is 1.
module zilla_irq_responder #(
    parameter int NEST_DEPTH = 4,
    parameter int ID_W       = 8,
    parameter int LP_W       = 8
) (
    input  logic                 zic_clk,
    input  logic                 zic_rst,
    zilla_irq_responder_if.slave bus
);

    localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
`ifdef ZILLA_IRQ_NEST_EN
    localparam logic [3:0] EFF_DEPTH = 4'(NEST_DEPTH);
`else
    localparam logic [3:0] EFF_DEPTH = 4'd1;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_CAPT = 2'd2,
        S_TRAP = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [LP_W-1:0] lp_q, lp_d;
    logic            ret_pend_q, ret_pend_d;
    logic [ID_W-1:0] id_q;
    logic            ack_q;
    logic            eoi_valid_q;
    logic [ID_W-1:0] eoi_id_q;
    logic [LP_W-1:0] active_q;
    logic            trap_req_q;
    logic [3:0]      depth_q;
    logic            ret_err_q;
    logic [ID_W-1:0] id_stk_q [NEST_DEPTH];
    logic [LP_W-1:0] lp_stk_q [NEST_DEPTH];

    logic             full_s, empty_s, accept_s;
    logic             push_s, pop_s, err_s, trap_clr_s;
    logic [IDX_W-1:0] push_idx_s, top_idx_s, below_idx_s;

    assign full_s      = (depth_q == EFF_DEPTH);
    assign empty_s     = (depth_q == 4'd0);
    assign push_idx_s  = depth_q[IDX_W-1:0];
    assign top_idx_s   = push_idx_s - IDX_W'(1);
    assign below_idx_s = push_idx_s - IDX_W'(2);
    assign accept_s    = bus.interrupt_request_i & bus.irq_global_en_i & ~bus.debug_mode_valid_i
                       & ~full_s & (bus.highest_pending_lvl_pr_i > active_q);

    // Next-state and stack-operation decode; a return outside IDLE is parked one-deep.
    always_comb begin
        state_d    = state_q;
        lp_d       = lp_q;
        ret_pend_d = ret_pend_q;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        err_s      = 1'b0;
        trap_clr_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.irq_ret_i || ret_pend_q) begin
                    ret_pend_d = ret_pend_q & bus.irq_ret_i;
                    if (empty_s) begin
                        err_s = 1'b1;
                    end else begin
                        pop_s = 1'b1;
                    end
                end else if (accept_s) begin
                    state_d = S_ACK;
                    lp_d    = bus.highest_pending_lvl_pr_i;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                ret_pend_d = ret_pend_q | bus.irq_ret_i;
                state_d    = S_CAPT;
            end
            S_CAPT: begin
                ret_pend_d = ret_pend_q | bus.irq_ret_i;
                push_s     = 1'b1;
                state_d    = S_TRAP;
            end
            S_TRAP: begin
                ret_pend_d = ret_pend_q | bus.irq_ret_i;
                if (bus.trap_ack_i) begin
                    trap_clr_s = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    state_d = S_TRAP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state, latched claim priority and parked return.
    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            state_q    <= S_IDLE;
            lp_q       <= {LP_W{1'b0}};
            ret_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lp_q       <= lp_d;
            ret_pend_q <= ret_pend_d;
        end
    end

    // Active stack, registered ZIC/core outputs and the sticky return error.
    always_ff @(posedge zic_clk or negedge zic_rst) begin
        if (!zic_rst) begin
            ack_q       <= 1'b0;
            eoi_valid_q <= 1'b0;
            eoi_id_q    <= {ID_W{1'b0}};
            active_q    <= {LP_W{1'b0}};
            trap_req_q  <= 1'b0;
            id_q        <= {ID_W{1'b0}};
            depth_q     <= 4'd0;
            ret_err_q   <= 1'b0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                id_stk_q[i] <= {ID_W{1'b0}};
                lp_stk_q[i] <= {LP_W{1'b0}};
            end
        end else begin
            ack_q       <= (state_d == S_ACK);
            eoi_valid_q <= pop_s;
            eoi_id_q    <= pop_s ? id_stk_q[top_idx_s] : {ID_W{1'b0}};
            if (push_s) begin
                id_stk_q[push_idx_s] <= bus.zic_ack_int_id_i;
                lp_stk_q[push_idx_s] <= lp_q;
                depth_q              <= depth_q + 4'd1;
                active_q             <= lp_q;
            end else if (pop_s) begin
                depth_q  <= depth_q - 4'd1;
                active_q <= (depth_q > 4'd1) ? lp_stk_q[below_idx_s] : {LP_W{1'b0}};
            end
            if (push_s) begin
                trap_req_q <= 1'b1;
                id_q       <= bus.zic_ack_int_id_i;
            end else if (trap_clr_s) begin
                trap_req_q <= 1'b0;
            end
            if (err_s) begin
                ret_err_q <= 1'b1;
            end
        end
    end

    assign bus.zic_ack_read_valid_en_o = ack_q;
    assign bus.zic_eoi_valid_o         = eoi_valid_q;
    assign bus.zic_eoi_id_o            = eoi_id_q;
    assign bus.active_lvl_pr_o         = active_q;
    assign bus.trap_req_o              = trap_req_q;
    assign bus.trap_id_o               = id_q;
    assign bus.nest_depth_o            = depth_q;
    assign bus.ret_err_o               = ret_err_q;

endmodule

// File: doc/zilla_irq_responder.md
Name: zilla_irq_responder

Overview:
- Core-side responder for the ZIC interrupt protocol.
- Watches the ZIC interrupt request and pending level-priority.
- Claims interrupts by pulsing the ack-read enable and captures the acknowledged ID.
- Hands a trap request to the core pipeline, keeps a nesting stack of active (id, level-priority) pairs that drives active_lvl_pr back to the ZIC, and issues EOI on handler return.

Parameters:
- NEST_DEPTH, 4, maximum nested active interrupts (2..8).
- ID_W, 8, interrupt ID width.
- LP_W, 8, level-priority width.

Ports:
- zic_clk  in  1  clock.
- zic_rst  in  1  asynchronous, active-low reset.
- interrupt_request_i  in  1  interrupt request from the ZIC.
- highest_pending_lvl_pr_i  in  LP_W  level-priority of the highest pending interrupt.
- zic_ack_int_id_i  in  ID_W  acknowledged interrupt ID from the ZIC.
- zic_ack_read_valid_en_o  out  1  ack-read enable pulse to the ZIC.
- zic_eoi_valid_o  out  1  EOI pulse to the ZIC.
- zic_eoi_id_o  out  ID_W  ID being retired.
- active_lvl_pr_o  out  LP_W  current active level-priority to the ZIC.
- irq_global_en_i  in  1  core global interrupt enable.
- debug_mode_valid_i  in  1  core in debug mode; blocks acceptance.
- trap_req_o  out  1  interrupt trap request to the core.
- trap_id_o  out  ID_W  ID for the trap vector.
- trap_ack_i  in  1  core took the trap.
- irq_ret_i  in  1  one-cycle pulse on interrupt handler return.
- nest_depth_o  out  4  current stack occupancy.
- ret_err_o  out  1  sticky flag: return seen with an empty stack.

Behaviour:
- Reset values: all outputs 0, stack empty, FSM in IDLE, active_lvl_pr_o = 0.
- active_lvl_pr_o: lvl_pr of the stack top; 0 when the stack is empty. Registered; updates the cycle after a push or pop.
- accept = interrupt_request_i & irq_global_en_i & ~debug_mode_valid_i & ~full & (highest_pending_lvl_pr_i > active_lvl_pr_o), compared unsigned.
- FSM states: IDLE, ACK, CAPT, TRAP.
  - IDLE: if irq_ret_i, do the return path and stay in IDLE (return has priority over accept in the same cycle). Else if accept, go to ACK and latch highest_pending_lvl_pr_i into lp_q.
  - ACK: zic_ack_read_valid_en_o = 1 for exactly this one cycle. Go to CAPT.
  - CAPT: sample zic_ack_int_id_i into id_q and push (id_q, lp_q). Assert trap_req_o and trap_id_o from the next cycle. Go to TRAP.
  - TRAP: hold trap_req_o = 1 and trap_id_o stable until trap_ack_i. On the trap_ack_i cycle, deassert trap_req_o and go to IDLE.
- Latency: accept to ack pulse = 1 cycle; ack pulse to trap_req_o = 2 cycles.
- irq_ret_i outside IDLE is held pending (one-deep) and serviced on the first IDLE cycle.
- Return path:
  - Stack non-empty: pop; zic_eoi_valid_o = 1 for one cycle with zic_eoi_id_o = popped ID (the cycle after the return is serviced); nest_depth_o decrements.
  - Stack empty: no EOI pulse; ret_err_o set to 1 and held until reset.
- Full: nest_depth_o == effective depth. No new accept; requests are ignored until a pop.
- Push at full is impossible by construction, because accept is gated by ~full.
- Reset asserted mid-sequence: immediate return to IDLE, stack cleared, no EOI, all pulses dropped.
- debug_mode_valid_i or irq_global_en_i deasserting after ACK does not abort the sequence; the claim completes.

Optional Feature:
- Macro: ZILLA_IRQ_NEST_EN.
- Defined: effective depth = NEST_DEPTH; a higher-priority interrupt preempts an active handler.
- Undefined: effective depth = 1, no nesting. accept additionally requires an empty stack; nest_depth_o is 0 or 1.

Test Plan:
- Single claim: request=1, pending lp=0x20, enables=1, core acks 3 cycles after trap_req_o -> ack pulse 1 cycle after accept; trap_id_o = 0x05 (ZIC returns ID 5); active_lvl_pr_o = 0x20; irq_ret_i -> EOI pulse with ID 0x05, active_lvl_pr_o back to 0.
- Nesting (macro on): active lp=0x20; new request lp=0x40 (ID 9) -> claimed, depth 2, active 0x40. Request lp=0x10 -> ignored. Two returns -> EOI IDs 9 then 5.
- Full: NEST_DEPTH=2 with depth 2, request lp=0xFF -> no ack pulse; one return -> EOI, then the 0xFF request is claimed.
- Simultaneous: irq_ret_i and accept in the same IDLE cycle -> EOI issued first, claim begins on the following cycle.
- Empty-stack return: irq_ret_i with depth 0 -> no EOI, ret_err_o = 1 and held.
- Reset mid-TRAP: zic_rst low while trap_req_o=1 -> all outputs 0 asynchronously, depth 0; macro off -> a second request is ignored while depth=1.
